tdm_mux_scanner: RTL

Parametrised N-channel, W-bit registered multiplexer with a built-in time-division scanner. It succeeds the fixed 8:1 single-bit gate mux: it selects a full data word, registers the output, and in scan mode steps through all channels itself with a programmable dwell time. It sits between parallel sensor/data lanes and a single serial consumer, and reports which channel the current output word belongs to.

---
 rtl/tdm_mux_pkg.sv | 15 +
 rtl/mux_n.sv | 24 ++
 rtl/tdm_mux_scanner.sv | 99 +++++++++
 3 files changed

// File: rtl/tdm_mux_pkg.sv
// rtl/tdm_mux_pkg.sv - shared types and helpers for the TDM mux scanner
package tdm_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIXED,
    ST_SCAN
  } state_t;

  // Channel index width; a 2-channel mux still needs one select bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// rtl/mux_n.sv - combinational N:1 word mux, out-of-range select maps to channel 0
module mux_n #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic [N_CH*DATA_W-1:0] d,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      y,
  output logic [SEL_W-1:0]       sel_eff
);

  always_comb begin
    y       = d[DATA_W-1:0];
    sel_eff = '0;
    for (int k = 1; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        y       = d[k*DATA_W +: DATA_W];
        sel_eff = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/tdm_mux_scanner.sv
// rtl/tdm_mux_scanner.sv - registered N-channel word mux with auto-scan and dwell
module tdm_mux_scanner
  import tdm_mux_pkg::*;
#(
  parameter int  N_CH    = 8,
  parameter int  DATA_W  = 8,
  parameter int  DWELL_W = 4,
  localparam int SEL_W   = sel_width(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic [N_CH*DATA_W-1:0] d,
  output logic [DATA_W-1:0]      y,
  output logic [SEL_W-1:0]       ch,
  output logic                   valid,
  output logic                   wrap
);

  state_t             state;
  logic [SEL_W-1:0]   cur;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] limit;

  logic               scanning;
  logic               boundary;
  logic [SEL_W-1:0]   next_cur;
  logic [SEL_W-1:0]   scan_ch;
  logic [SEL_W-1:0]   mux_sel;
  logic [DATA_W-1:0]  mux_y;
  logic [SEL_W-1:0]   mux_ch;

  // Scan-entry cycles select from sel so the start channel shows immediately.
  assign scanning = mode && (state == ST_SCAN);
  assign boundary = (cnt == limit);
  assign next_cur = (cur == SEL_W'(N_CH - 1)) ? '0 : cur + SEL_W'(1);
  assign scan_ch  = boundary ? next_cur : cur;
  assign mux_sel  = scanning ? scan_ch : sel;

  mux_n #(
    .N_CH   (N_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_mux (
    .d       (d),
    .sel     (mux_sel),
    .y       (mux_y),
    .sel_eff (mux_ch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      cnt   <= '0;
      limit <= '0;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (!en) begin
      state <= ST_IDLE;
      cnt   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else if (!mode) begin
      state <= ST_FIXED;
      cnt   <= '0;
      y     <= mux_y;
      ch    <= mux_ch;
      valid <= 1'b1;
      wrap  <= 1'b0;
    end else begin
      state <= ST_SCAN;
      y     <= mux_y;
      ch    <= mux_ch;
      valid <= 1'b1;
      if (state != ST_SCAN) begin
        cur   <= mux_ch;
        cnt   <= '0;
        limit <= dwell;
        wrap  <= 1'b0;
      end else if (boundary) begin
        // New dwell only takes effect here, at the channel boundary.
        cur   <= next_cur;
        cnt   <= '0;
        limit <= dwell;
        wrap  <= (next_cur == '0);
      end else begin
        cnt   <= cnt + DWELL_W'(1);
        wrap  <= 1'b0;
      end
    end
  end

endmodule
